// File: rtl/config_mac_pkg.sv
// config_mac_pkg: shared types for the configurable multiply-accumulate unit.
//   mode_e      - precision mode (FULL: 1 lane, HALF: 2 lanes, QUARTER: 4 lanes, RSVD)
//   run_state_e - accumulation run tracking (idle / inside a run)
//   lane_count  - number of packed lanes for a given mode (RSVD behaves as one lane)
package config_mac_pkg;

  typedef enum logic [1:0] {
    FULL    = 2'd0,
    HALF    = 2'd1,
    QUARTER = 2'd2,
    RSVD    = 2'd3
  } mode_e;

  typedef enum logic {
    RUN_IDLE   = 1'b0,
    RUN_ACTIVE = 1'b1
  } run_state_e;

  function automatic int unsigned lane_count(input mode_e m);
    case (m)
      HALF:    return 2;
      QUARTER: return 4;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/config_lane_multiplier.sv
// config_lane_multiplier: combinational signed multiplier with lane splitting.
//   mode         in  precision mode selecting 1, 2 or 4 signed lanes
//   multiplier   in  WIDTH-bit packed signed lanes
//   multiplicand in  WIDTH-bit packed signed lanes
//   product      out 2*WIDTH-bit packed exact lane products; lane L of an
//                    N-lane mode sits at [L*2*WIDTH/N +: 2*WIDTH/N]
module config_lane_multiplier
  import config_mac_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  mode_e              mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned QW = WIDTH / 4;

  logic signed [PW-1:0] p_full;
  logic        [PW-1:0] p_half;
  logic        [PW-1:0] p_qtr;

  // Single full-width lane.
  assign p_full = PW'($signed(multiplier)) * PW'($signed(multiplicand));

  // Two half-width lanes, each product WIDTH bits wide.
  for (genvar l = 0; l < 2; l++) begin : g_half
    logic signed [WIDTH-1:0] p;
    assign p = WIDTH'($signed(multiplier[l*HW +: HW])) *
               WIDTH'($signed(multiplicand[l*HW +: HW]));
    assign p_half[l*WIDTH +: WIDTH] = p;
  end

  // Four quarter-width lanes, each product WIDTH/2 bits wide.
  for (genvar l = 0; l < 4; l++) begin : g_qtr
    logic signed [HW-1:0] p;
    assign p = HW'($signed(multiplier[l*QW +: QW])) *
               HW'($signed(multiplicand[l*QW +: QW]));
    assign p_qtr[l*HW +: HW] = p;
  end

  // Lane-layout select.
  always_comb begin
    product = p_full;
    case (lane_count(mode))
      2:       product = p_half;
      4:       product = p_qtr;
      default: product = p_full;
    endcase
  end

endmodule

// File: rtl/config_mac_unit.sv
// config_mac_unit: packed-lane signed multiply-accumulate with valid/ready
// handshakes and per-run error reporting.
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid / in_ready    operand beat handshake
//   multiplier/multiplicand WIDTH-bit packed signed lanes
//   mode                   0 FULL, 1 HALF, 2 QUARTER, 3 reserved
//   in_last                final beat of an accumulation run
//   out_valid / out_ready  result handshake
//   result                 ACC_WIDTH-bit packed signed per-lane sums
//   out_err                run saw a mode change or a reserved mode
// Build option: define CONFIG_MAC_SATURATE_EN to clamp each lane accumulator
// to its signed range instead of wrapping.
// WIDTH must be a multiple of 4 and >= 8; ACC_WIDTH a multiple of 4 and >= 2*WIDTH.
module config_mac_unit
  import config_mac_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [1:0]           mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 out_err
);

  localparam int unsigned PW = 2 * WIDTH;

  mode_e              in_mode;
  logic               advance;
  logic               accept;
  logic               run_first;
  logic               beat_bad;
  mode_e              beat_mode;
  logic [PW-1:0]      lane_prod;

  run_state_e         run_state;
  mode_e              run_mode;

  logic               s1_valid;
  logic               s1_first;
  logic               s1_last;
  logic               s1_bad;
  mode_e              s1_mode;
  logic [PW-1:0]      s1_prod;

  logic [ACC_WIDTH-1:0] acc;
  logic                 acc_err;
  logic                 s2_fire;

  logic [2:0][ACC_WIDTH-1:0] acc_opt;
  logic [ACC_WIDTH-1:0]      acc_sel;

  assign in_mode = mode_e'(mode);

  // A stalled output freezes the whole pipeline; reset keeps the input open.
  assign in_ready = !rst_n || out_ready || !out_valid;
  assign advance  = in_ready;
  assign accept   = in_valid && in_ready;

  // Mode checks against the run's latched mode; a bad beat contributes zero.
  assign run_first = (run_state == RUN_IDLE);
  assign beat_mode = run_first ? in_mode : run_mode;
  assign beat_bad  = (in_mode == RSVD) || (!run_first && (in_mode != run_mode));

  config_lane_multiplier #(
    .WIDTH (WIDTH)
  ) u_mult (
    .mode         (in_mode),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .product      (lane_prod)
  );

  // Run tracking and stage 1 (registered lane products).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_state <= RUN_IDLE;
      run_mode  <= FULL;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_bad    <= 1'b0;
      s1_mode   <= FULL;
      s1_prod   <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        run_state <= in_last ? RUN_IDLE : RUN_ACTIVE;
        if (run_first) run_mode <= in_mode;
        s1_first <= run_first;
        s1_last  <= in_last;
        s1_bad   <= beat_bad;
        s1_mode  <= beat_mode;
        s1_prod  <= beat_bad ? '0 : lane_prod;
      end
    end
  end

  // Per-lane next accumulator value for each lane layout.
  for (genvar k = 0; k < 3; k++) begin : g_mode
    localparam int unsigned N  = 1 << k;
    localparam int unsigned LW = ACC_WIDTH / N;
    localparam int unsigned LP = PW / N;
    for (genvar l = 0; l < N; l++) begin : g_lane
      logic signed [LW-1:0] base;
      logic signed [LW-1:0] addend;
      logic signed [LW:0]   sum;
      logic        [LW-1:0] lane_nxt;

      assign base   = s1_first ? '0 : $signed(acc[l*LW +: LW]);
      assign addend = LW'($signed(s1_prod[l*LP +: LP]));
      assign sum    = (LW+1)'(base) + (LW+1)'(addend);
`ifdef CONFIG_MAC_SATURATE_EN
      // Overflow when the carry-out disagrees with the lane sign bit.
      localparam logic [LW-1:0] LANE_MAX = {1'b0, {(LW-1){1'b1}}};
      localparam logic [LW-1:0] LANE_MIN = {1'b1, {(LW-1){1'b0}}};
      assign lane_nxt = (sum[LW] != sum[LW-1]) ? (sum[LW] ? LANE_MIN : LANE_MAX)
                                               : sum[LW-1:0];
`else
      assign lane_nxt = sum[LW-1:0];
`endif
      assign acc_opt[k][l*LW +: LW] = lane_nxt;
    end
  end

  always_comb begin
    acc_sel = acc_opt[0];
    case (s1_mode)
      HALF:    acc_sel = acc_opt[1];
      QUARTER: acc_sel = acc_opt[2];
      default: acc_sel = acc_opt[0];
    endcase
  end

  // Stage 2 (accumulate) and registered output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      acc_err   <= 1'b0;
      s2_fire   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      out_err   <= 1'b0;
    end else if (advance) begin
      s2_fire <= s1_valid && s1_last;
      if (s1_valid) begin
        acc     <= acc_sel;
        acc_err <= (s1_first ? 1'b0 : acc_err) | s1_bad;
      end
      out_valid <= s2_fire;
      if (s2_fire) begin
        result  <= acc;
        out_err <= acc_err;
      end
    end
  end

endmodule

// File: tb/tb_config_mac_unit.sv
module tb_config_mac_unit;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  multiplier;
  logic [W-1:0]  multiplicand;
  logic [1:0]    mode;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] result;
  logic          out_err;

  // Narrow-accumulator instance for overflow behaviour.
  logic          in_valid16;
  logic          in_ready16;
  logic [W-1:0]  mult16;
  logic [W-1:0]  mcand16;
  logic [1:0]    mode16;
  logic          last16;
  logic          out_valid16;
  logic          out_ready16;
  logic [15:0]   result16;
  logic          out_err16;

  config_mac_unit #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .mode         (mode),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .out_err      (out_err)
  );

  config_mac_unit #(.WIDTH(W), .ACC_WIDTH(16)) dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid16),
    .in_ready     (in_ready16),
    .multiplier   (mult16),
    .multiplicand (mcand16),
    .mode         (mode16),
    .in_last      (last16),
    .out_valid    (out_valid16),
    .out_ready    (out_ready16),
    .result       (result16),
    .out_err      (out_err16)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        last;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[15];
  int   tests;
  int   fails;
  int   hs_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard consumer: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_count++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h, required no output", result);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("out_err", 32'(out_err), 32'(mon_e.err));
      end
    end
  end

  // Drive one beat; expected result is queued when the beat closes a run.
  task automatic send(input vec_t v);
    logic ok;
    exp_t e;
    in_valid     = 1'b1;
    mode         = v.mode;
    multiplier   = v.a;
    multiplicand = v.b;
    in_last      = v.last;
    ok           = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0, required 1 within 50 cycles");
    end
    if (v.last) begin
      e.res = v.exp_res;
      e.err = v.exp_err;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   hs0;
    logic got;
    logic [15:0] exp16;

    tests = 0; fails = 0; hs_count = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    multiplier = '0; multiplicand = '0; mode = 2'd0; in_last = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; mult16 = '0; mcand16 = '0;
    mode16 = 2'd0; last16 = 1'b0;

    //            mode   a      b      last  expected      err
    vt[0]  = '{2'd0, 8'h80, 8'h10, 1'b1, 32'hFFFFF800, 1'b0};  // -128*16
    vt[1]  = '{2'd0, 8'h7F, 8'h7F, 1'b0, 32'h0,        1'b0};
    vt[2]  = '{2'd0, 8'h7F, 8'h7F, 1'b0, 32'h0,        1'b0};
    vt[3]  = '{2'd0, 8'h7F, 8'h7F, 1'b1, 32'h0000BD03, 1'b0};  // 3*16129
    vt[4]  = '{2'd0, 8'h01, 8'h01, 1'b1, 32'h00000001, 1'b0};
    vt[5]  = '{2'd1, 8'h78, 8'h77, 1'b1, 32'h0031FFC8, 1'b0};  // {7,-8}*{7,7}
    vt[6]  = '{2'd2, 8'hAA, 8'hAA, 1'b1, 32'h04040404, 1'b0};  // -2*-2 x4
    vt[7]  = '{2'd1, 8'h88, 8'h88, 1'b0, 32'h0,        1'b0};
    vt[8]  = '{2'd1, 8'h88, 8'h88, 1'b1, 32'h00800080, 1'b0};  // 2*64 per lane
    vt[9]  = '{2'd2, 8'h6C, 8'hAA, 1'b1, 32'hFE040200, 1'b0};  // {1,-2,-1,0}*-2
    vt[10] = '{2'd0, 8'h03, 8'h03, 1'b0, 32'h0,        1'b0};
    vt[11] = '{2'd1, 8'h78, 8'h77, 1'b1, 32'h00000009, 1'b1};  // mode change
    vt[12] = '{2'd3, 8'h05, 8'h05, 1'b1, 32'h00000000, 1'b1};  // reserved mode
    vt[13] = '{2'd0, 8'h02, 8'h03, 1'b1, 32'h00000006, 1'b0};  // error cleared
    vt[14] = '{2'd0, 8'h80, 8'h80, 1'b1, 32'h00004000, 1'b0};  // -128*-128

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: back-to-back beats, no bubbles
    for (int i = 0; i < 15; i++) send(vt[i]);
    repeat (6) @(posedge clk);
    #1;

    // Latency: out_valid rises exactly two edges after the accepting edge
    v = '{2'd0, 8'h02, 8'h02, 1'b1, 32'h00000004, 1'b0};
    send(v);
    @(posedge clk);
    #1;
    check("lat_edge1_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge2_out_valid", 32'(out_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // Stall: result held while out_ready=0, then exactly one handshake
    out_ready = 1'b0;
    v = '{2'd0, 8'h05, 8'h05, 1'b1, 32'h00000019, 1'b0};
    send(v);
    repeat (2) @(posedge clk);
    #1;
    hs0 = hs_count;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_result", result, 32'h00000019);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("stall_handshakes", 32'(hs_count - hs0), 32'd1);

    // Reset mid-run discards the partial run
    v = '{2'd0, 8'h03, 8'h03, 1'b0, 32'h0, 1'b0};
    send(v);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_out_err", 32'(out_err), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hs0 = hs_count;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_output", 32'(hs_count - hs0), 32'd0);
    // HALF run after reset: no stale FULL mode, so no error
    v = '{2'd1, 8'h78, 8'h77, 1'b1, 32'h0031FFC8, 1'b0};
    send(v);
    repeat (4) @(posedge clk);
    #1;

    // Narrow accumulator overflow: 3 x 127*127 = 48387
`ifdef CONFIG_MAC_SATURATE_EN
    exp16 = 16'h7FFF;
`else
    exp16 = 16'hBD03;
`endif
    in_valid16 = 1'b1; mode16 = 2'd0; mult16 = 8'h7F; mcand16 = 8'h7F; last16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    last16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid16) begin
        got = 1'b1;
        break;
      end
    end
    check("ovf_seen", 32'(got), 32'd1);
    check("ovf_result", 32'(result16), 32'(exp16));
    check("ovf_out_err", 32'(out_err16), 32'd0);

    // Drain the scoreboard
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
